// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply datapath: default sizes,
// drain FSM state encoding and the result beat layout.
package mm_pkg;

  localparam int MM_N      = 16;
  localparam int MM_DATA_W = 32;
  localparam int MM_ADDR_W = $clog2(MM_N * MM_N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    FLUSH  = 2'd2,
    FINISH = 2'd3
  } drain_state_e;

  // One streamed result element with its row/matrix boundary tags.
  typedef struct packed {
    logic [MM_DATA_W-1:0] data;
    logic                 eol;
    logic                 last;
  } res_beat_t;

endpackage

// File: rtl/mm_fwft_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// rdata whenever empty is low; pop consumes it at the next edge. A push
// and a pop in the same cycle are accepted even when the FIFO is full.
module mm_fwft_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the head being popped this cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign count   = cnt;

  // Storage: data array needs no reset, occupancy is tracked by cnt.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/result_drain.sv
// Result drain: after the compute unit finishes, reads the N x N result
// matrix from BRAM C in row-major order and streams it over valid/ready.
// Reads are prefetched against a credit count covering both the FIFO
// occupancy and the reads still in the BRAM pipeline.
module result_drain
  import mm_pkg::*;
#(
  parameter int N      = MM_N,
  parameter int DATA_W = MM_DATA_W,
  parameter int ADDR_W = $clog2(N * N),
  parameter int RD_LAT = 2,
  parameter int FIFO_D = RD_LAT + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] c_rd_addr,
  input  logic [DATA_W-1:0] c_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_eol,
  output logic              m_last
);

  localparam int STAGES = RD_LAT - 1;
  localparam int CNT_W  = $clog2(FIFO_D + 1);
  localparam int IF_W   = $clog2(RD_LAT + 1);
  localparam int COL_W  = (N > 1) ? $clog2(N) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N * N - 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              eol;
    logic              last;
  } beat_t;

  drain_state_e            state_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [COL_W-1:0]        col_q;
  logic                    busy_q, done_q;

  logic [STAGES:0]         vld_pipe;
  logic [STAGES:0][1:0]    tag_pipe;   // {eol, last} travelling with each read
  logic [IF_W-1:0]         inflight;

  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_empty, fifo_full;
  beat_t                   wr_beat, head;

  logic                    credit_ok, issue, push, pop;
  logic                    eol_now, last_now, drain_done;

  // Reads launched but not yet written into the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= STAGES; i++) inflight = inflight + IF_W'(vld_pipe[i]);
  end

  // The credit compare is what keeps the FIFO from overflowing: the full
  // flag alone cannot see reads still in the BRAM pipeline.
  assign credit_ok = (int'(fifo_count) + int'(inflight)) < FIFO_D;
  assign issue     = (state_q == READ) && credit_ok && !fifo_full;
  assign eol_now   = (col_q == COL_W'(N - 1));
  assign last_now  = (addr_q == LAST_ADDR);

  assign push      = vld_pipe[STAGES];
  assign wr_beat   = '{data: c_rd_data, eol: tag_pipe[STAGES][1], last: tag_pipe[STAGES][0]};
  assign pop       = m_valid && m_ready;

  // Run is complete once the final beat leaves and nothing is left behind it.
  assign drain_done = (inflight == '0) &&
                      (fifo_empty || (pop && fifo_count == CNT_W'(1)));

  // In-flight valid/tag shift register matching the BRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[0] <= issue;
      tag_pipe[0] <= {eol_now, last_now};
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Drain FSM with address/column counters and registered busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= READ;
            busy_q  <= 1'b1;
            addr_q  <= '0;
            col_q   <= '0;
          end
        end
        READ: begin
          if (issue) begin
            // Address parks on the final element rather than wrapping.
            if (last_now) begin
              state_q <= FLUSH;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
              col_q  <= eol_now ? '0 : col_q + COL_W'(1);
            end
          end
        end
        FLUSH: begin
          if (drain_done) begin
            state_q <= FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        FINISH: begin
          state_q <= IDLE;
          addr_q  <= '0;
          col_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mm_fwft_fifo #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_beat),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign c_rd_addr = addr_q;
  assign m_valid   = !fifo_empty;
  assign m_data    = head.data;
  assign m_eol     = head.eol;
  assign m_last    = head.last;

endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain: BRAM C model with C[i] = 3i-100, randomized sink
// back-pressure, beats compared against the row-major reference sequence.
module tb_result_drain;

  localparam int N      = 16;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int RD_LAT = 2;
  localparam int FIFO_D = RD_LAT + 2;
  localparam int NB     = N * N;

  logic              clk = 1'b0;
  logic              rst, start, busy, done;
  logic [ADDR_W-1:0] c_rd_addr;
  logic [DATA_W-1:0] c_rd_data, m_data;
  logic              m_valid, m_ready, m_eol, m_last;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] mem   [NB];
  logic [DATA_W-1:0] rpipe [RD_LAT];
  logic [DATA_W-1:0] got_data [$];
  logic              got_eol  [$];
  logic              got_last [$];

  always #5 clk = ~clk;

  initial for (int i = 0; i < NB; i++) mem[i] = DATA_W'(3 * i - 100);

  // BRAM C: address sampled at the edge, data out RD_LAT cycles after presentation.
  always @(posedge clk) begin
    rpipe[0] <= mem[c_rd_addr];
    for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  assign c_rd_data = rpipe[RD_LAT-1];

  result_drain #(.N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .FIFO_D(FIFO_D)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .c_rd_addr(c_rd_addr), .c_rd_data(c_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_eol(m_eol), .m_last(m_last)
  );

  // Reference: beat i carries C[i] = 3i-100, eol on the last column, last on i = N*N-1.
  function automatic int count_bad();
    int bad = 0;
    for (int i = 0; i < got_data.size(); i++) begin
      if (got_data[i] !== DATA_W'(3 * i - 100) ||
          got_eol[i]  !== ((i % N) == N - 1) ||
          got_last[i] !== (i == NB - 1)) bad++;
    end
    return bad;
  endfunction

  task automatic clear_q();
    got_data.delete(); got_eol.delete(); got_last.delete();
  endtask

  // Start pulse accepted at edge T; returns at the negedge in cycle (T, T+1].
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Sink: one iteration per cycle, k counts edges since the start edge.
  // mode 0: ready always; mode 1: random 50%. Records beats and stall violations.
  task automatic drain(input int mode, input int k0, input int stop_beats, input int inj_k,
                       output int t_valid, output int t_done, output int n_unstable);
    logic              prev_stall;
    logic [DATA_W-1:0] pd;
    logic              pe, pl;
    prev_stall = 1'b0; pd = '0; pe = 1'b0; pl = 1'b0;
    t_valid = -1; t_done = -1; n_unstable = 0;
    for (int k = k0; k < k0 + 4000; k++) begin
      if (k != k0) @(negedge clk);
      m_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      start   = (k == inj_k);
      if (prev_stall && (!m_valid || m_data !== pd || m_eol !== pe || m_last !== pl))
        n_unstable++;
      if (m_valid && t_valid < 0) t_valid = k;
      if (done) begin t_done = k; break; end
      if (m_valid && m_ready) begin
        got_data.push_back(m_data); got_eol.push_back(m_eol); got_last.push_back(m_last);
      end
      prev_stall = m_valid && !m_ready;
      pd = m_data; pe = m_eol; pl = m_last;
      if (stop_beats > 0 && got_data.size() == stop_beats) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    checks++; if (c_rd_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", c_rd_addr); end
    rst = 1'b0;
  endtask

  task automatic test_full_rate();
    int tv, td, nu, bad;
    clear_q(); m_ready = 1'b1;
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_high: got %b want 1", busy); end
    drain(0, 1, 0, -1, tv, td, nu);
    bad = count_bad();
    checks++; if (got_data.size() !== NB) begin errors++; $display("FAIL full_count: got %0d want %0d", got_data.size(), NB); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL full_data: got %0d bad beats want 0", bad); end
    checks++; if (tv !== RD_LAT + 2) begin errors++; $display("FAIL full_first_valid: got T+%0d want T+%0d", tv, RD_LAT + 2); end
    checks++; if (td !== RD_LAT + NB + 2) begin errors++; $display("FAIL full_done_time: got T+%0d want T+%0d", td, RD_LAT + NB + 2); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_at_done: got %b want 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL full_after_done: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_backpressure();
    int tv, td, nu, bad;
    logic [ADDR_W-1:0] a5;
    clear_q(); m_ready = 1'b0;
    pulse_start();
    a5 = '0;
    for (int k = 1; k <= 20; k++) begin
      if (k != 1) @(negedge clk);
      m_ready = 1'b0;
      if (k == 5) a5 = c_rd_addr;
    end
    checks++; if (a5 !== ADDR_W'(FIFO_D)) begin errors++; $display("FAIL bp_addr_k5: got %0d want %0d", a5, FIFO_D); end
    checks++; if (c_rd_addr !== ADDR_W'(FIFO_D)) begin errors++; $display("FAIL bp_addr_stall: got %0d want %0d", c_rd_addr, FIFO_D); end
    checks++; if (m_valid !== 1'b1 || m_data !== DATA_W'(-100)) begin errors++; $display("FAIL bp_head: got v=%b d=%0d want v=1 d=-100", m_valid, $signed(m_data)); end
    @(negedge clk);
    drain(0, 21, 0, -1, tv, td, nu);
    bad = count_bad();
    checks++; if (got_data.size() !== NB) begin errors++; $display("FAIL bp_count: got %0d want %0d", got_data.size(), NB); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_data: got %0d bad beats want 0", bad); end
    checks++; if (td < 0) begin errors++; $display("FAIL bp_done: got no done want done"); end
  endtask

  task automatic test_random_ready();
    int tv, td, nu, bad;
    clear_q(); m_ready = 1'b0;
    pulse_start();
    drain(1, 1, 0, -1, tv, td, nu);
    bad = count_bad();
    checks++; if (got_data.size() !== NB) begin errors++; $display("FAIL rnd_count: got %0d want %0d", got_data.size(), NB); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rnd_data: got %0d bad beats want 0", bad); end
    checks++; if (nu !== 0) begin errors++; $display("FAIL rnd_stall_stable: got %0d violations want 0", nu); end
    checks++; if (td < 0) begin errors++; $display("FAIL rnd_done: got no done want done"); end
  endtask

  task automatic test_back_to_back();
    int tv, td, nu, bad, act;
    clear_q(); m_ready = 1'b1;
    pulse_start();
    drain(1, 1, 0, 50, tv, td, nu);
    bad = count_bad();
    checks++; if (got_data.size() !== NB || bad !== 0) begin errors++; $display("FAIL b2b_ignored_start: got %0d beats %0d bad want %0d beats 0 bad", got_data.size(), bad, NB); end
    act = 0;
    repeat (10) begin @(negedge clk); if (busy || m_valid || done) act++; end
    checks++; if (act !== 0) begin errors++; $display("FAIL b2b_idle_after: got %0d active cycles want 0", act); end
    clear_q();
    pulse_start();
    drain(0, 1, 0, -1, tv, td, nu);
    bad = count_bad();
    checks++; if (got_data.size() !== NB || bad !== 0) begin errors++; $display("FAIL b2b_rerun: got %0d beats %0d bad want %0d beats 0 bad", got_data.size(), bad, NB); end
    checks++; if (td !== RD_LAT + NB + 2) begin errors++; $display("FAIL b2b_rerun_done: got T+%0d want T+%0d", td, RD_LAT + NB + 2); end
  endtask

  task automatic test_mid_reset();
    int tv, td, nu, bad, act;
    clear_q(); m_ready = 1'b1;
    pulse_start();
    drain(1, 1, 100, -1, tv, td, nu);
    checks++; if (got_data.size() !== 100) begin errors++; $display("FAIL mrst_beats: got %0d want 100", got_data.size()); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0 || c_rd_addr !== '0) begin
      errors++; $display("FAIL mrst_outputs: got busy=%b done=%b valid=%b addr=%0d want 0 0 0 0", busy, done, m_valid, c_rd_addr);
    end
    act = 0;
    repeat (300) begin @(negedge clk); if (done || m_valid || busy) act++; end
    checks++; if (act !== 0) begin errors++; $display("FAIL mrst_no_done: got %0d active cycles want 0", act); end
    clear_q();
    pulse_start();
    drain(0, 1, 0, -1, tv, td, nu);
    bad = count_bad();
    checks++; if (got_data.size() == 0 || got_data[0] !== DATA_W'(-100)) begin errors++; $display("FAIL mrst_first: got %0d beats want first=-100", got_data.size()); end
    checks++; if (got_data.size() !== NB || bad !== 0) begin errors++; $display("FAIL mrst_rerun: got %0d beats %0d bad want %0d beats 0 bad", got_data.size(), bad, NB); end
  endtask

  task automatic test_start_with_rst();
    int act;
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    act = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || m_valid || done || c_rd_addr !== '0) act++;
    end
    checks++; if (act !== 0) begin errors++; $display("FAIL start_rst_idle: got %0d active cycles want 0", act); end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_random_ready();
    test_back_to_back();
    test_mid_reset();
    test_start_with_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
